// File: rtl/mem_arbiter_rr.sv
// Shared-memory arbiter: N clients, one outstanding memory transaction at a time,
// round-robin or fixed-priority winner selection.
//
// state | meaning
// IDLE  | no transaction; requests are sampled and a winner is latched
// BUSY  | latched request driven to memory until mem_resp completes it
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             cl_read,
  input  logic [NUM_PORTS-1:0]             cl_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  cl_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  cl_wdata,
  output logic [NUM_PORTS-1:0]             cl_resp,
  output logic [DATA_WIDTH-1:0]            cl_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_resp,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_grant_idx;
  logic [IDX_W-1:0]      w_grant_nxt;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      w_rr_nxt;
  logic [IDX_W-1:0]      w_win_idx;
  logic [ADDR_WIDTH-1:0] r_lat_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_lat_wdata;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic                  r_lat_op;     // 1 = write, 0 = read
  logic                  w_op_nxt;
  logic [NUM_PORTS-1:0]  w_req;
  logic                  w_any_req;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned     ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    return IDX_W'(sum % 32'(NUM_PORTS));
  endfunction

  assign w_req     = cl_read | cl_write;
  assign w_any_req = |w_req;
  assign cl_rdata  = mem_rdata;

  // Both searches run downward and overwrite, so the last hit is the closest one.
  always_comb begin
    w_win_idx = '0;
    if (FIXED_PRIO != 0) begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (w_req[k]) w_win_idx = IDX_W'(k);
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (w_req[wrap_idx(r_rr_ptr, 32'(k))]) w_win_idx = wrap_idx(r_rr_ptr, 32'(k));
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_idx;
    w_rr_nxt    = r_rr_ptr;
    w_addr_nxt  = r_lat_addr;
    w_wdata_nxt = r_lat_wdata;
    w_op_nxt    = r_lat_op;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_win_idx;
          w_addr_nxt  = cl_address[32'(w_win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
          w_wdata_nxt = cl_wdata[32'(w_win_idx) * DATA_WIDTH +: DATA_WIDTH];
          w_op_nxt    = cl_write[w_win_idx];
        end
      end
      BUSY: begin
        if (mem_resp) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = wrap_idx(r_grant_idx, 32'd1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_lat_op    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_lat_addr  <= w_addr_nxt;
      r_lat_wdata <= w_wdata_nxt;
      r_lat_op    <= w_op_nxt;
    end
  end

  // Outputs are forced quiet while rst is high, even if the FSM is still BUSY.
  always_comb begin
    cl_resp     = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    if (!rst) begin
      mem_address = r_lat_addr;
      mem_wdata   = r_lat_wdata;
      if (r_state == BUSY) begin
        mem_write            = r_lat_op;
        mem_read             = !r_lat_op;
        cl_resp[r_grant_idx] = mem_resp;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: three instances (2-port RR, 2-port fixed
// priority, 4-port RR) share one set of client/memory stimulus.
module tb_mem_arbiter_rr;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cl_read;
  logic [3:0]    cl_write;
  logic [4*AW-1:0] cl_address;
  logic [4*DW-1:0] cl_wdata;
  logic          mem_resp;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    resp2, respf;
  logic [3:0]    resp4;
  logic [DW-1:0] rdata2, rdataf, rdata4;
  logic          mrd[3];
  logic          mwr[3];
  logic [AW-1:0] maddr[3];
  logic [DW-1:0] mwd[3];
  logic [3:0]    resp_all[3];
  logic [DW-1:0] rd_all[3];

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) u_rr2 (
    .clk(clk), .rst(rst), .cl_read(cl_read[1:0]), .cl_write(cl_write[1:0]),
    .cl_address(cl_address[2*AW-1:0]), .cl_wdata(cl_wdata[2*DW-1:0]),
    .cl_resp(resp2), .cl_rdata(rdata2), .mem_read(mrd[0]), .mem_write(mwr[0]),
    .mem_address(maddr[0]), .mem_wdata(mwd[0]), .mem_resp(mem_resp), .mem_rdata(mem_rdata));

  mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) u_fp2 (
    .clk(clk), .rst(rst), .cl_read(cl_read[1:0]), .cl_write(cl_write[1:0]),
    .cl_address(cl_address[2*AW-1:0]), .cl_wdata(cl_wdata[2*DW-1:0]),
    .cl_resp(respf), .cl_rdata(rdataf), .mem_read(mrd[1]), .mem_write(mwr[1]),
    .mem_address(maddr[1]), .mem_wdata(mwd[1]), .mem_resp(mem_resp), .mem_rdata(mem_rdata));

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) u_rr4 (
    .clk(clk), .rst(rst), .cl_read(cl_read), .cl_write(cl_write),
    .cl_address(cl_address), .cl_wdata(cl_wdata),
    .cl_resp(resp4), .cl_rdata(rdata4), .mem_read(mrd[2]), .mem_write(mwr[2]),
    .mem_address(maddr[2]), .mem_wdata(mwd[2]), .mem_resp(mem_resp), .mem_rdata(mem_rdata));

  assign resp_all[0] = {2'b00, resp2};
  assign resp_all[1] = {2'b00, respf};
  assign resp_all[2] = resp4;
  assign rd_all[0]   = rdata2;
  assign rd_all[1]   = rdataf;
  assign rd_all[2]   = rdata4;

  typedef struct packed {
    logic [1:0]    port;
    logic          op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t cur[3];
  logic busy[3];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int d, input int p, input logic op,
                      input logic [AW-1:0] a, input logic [DW-1:0] w);
    exp_t e;
    e.port = 2'(p); e.op = op; e.addr = a; e.wdata = w;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic push_all(input int p0, input int p1, input int p2, input logic op,
                          input logic [AW-1:0] a, input logic [DW-1:0] w);
    push(0, p0, op, a, w);
    push(1, p1, op, a, w);
    push(2, p2, op, a, w);
  endtask

  task automatic pop(input int d, output exp_t e, output logic ok);
    ok = 1'b0;
    e  = '0;
    if (qsize(d) > 0) begin
      ok = 1'b1;
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
  endtask

  task automatic drive(input int p, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] w);
    cl_read[p]              = rd;
    cl_write[p]             = wr;
    cl_address[p*AW +: AW]  = a;
    cl_wdata[p*DW +: DW]    = w;
  endtask

  function automatic logic any_strobe();
    return mrd[0] | mwr[0] | mrd[1] | mwr[1] | mrd[2] | mwr[2];
  endfunction

  task automatic check_fields(input int d);
    check($sformatf("mem_write[%0d]", d), 32'(mwr[d]), 32'(cur[d].op));
    check($sformatf("mem_read[%0d]", d), 32'(mrd[d]), 32'(!cur[d].op));
    check($sformatf("mem_address[%0d]", d), 32'(maddr[d]), 32'(cur[d].addr));
    check($sformatf("mem_wdata[%0d]", d), 32'(mwd[d]), 32'(cur[d].wdata));
  endtask

  // Requests must already be driven before the next rising edge.
  task automatic await_grant();
    int   n = 0;
    exp_t e;
    logic ok;
    do begin
      @(negedge clk);
      n++;
    end while (!any_strobe() && n < 20);
    check("grant_latency", 32'(n), 32'd1);
    for (int d = 0; d < 3; d++) begin
      busy[d] = mrd[d] | mwr[d];
      if (busy[d]) begin
        pop(d, e, ok);
        check($sformatf("grant_expected[%0d]", d), 32'(ok), 32'd1);
        cur[d] = e;
        if (ok) check_fields(d);
        else busy[d] = 1'b0;
      end else begin
        check($sformatf("no_grant_pending[%0d]", d), 32'(qsize(d)), 32'd0);
      end
    end
  endtask

  task automatic hold(input int lat, input logic perturb);
    if (perturb) begin
      cl_address = ~cl_address;
      cl_wdata   = ~cl_wdata;
    end
    repeat (lat) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (busy[d]) check_fields(d);
        check($sformatf("resp_early[%0d]", d), 32'(resp_all[d]), 32'd0);
      end
    end
  endtask

  task automatic respond(input logic [DW-1:0] rdata);
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("cl_resp[%0d]", d), 32'(resp_all[d]),
            busy[d] ? 32'(4'(1 << cur[d].port)) : 32'd0);
      check($sformatf("cl_rdata[%0d]", d), 32'(rd_all[d]), 32'(rdata));
    end
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("idle_gap_strobe[%0d]", d), 32'(mrd[d] | mwr[d]), 32'd0);
      check($sformatf("resp_one_cycle[%0d]", d), 32'(resp_all[d]), 32'd0);
    end
  endtask

  task automatic serve(input int lat, input logic [DW-1:0] rdata, input logic perturb);
    await_grant();
    hold(lat, perturb);
    respond(rdata);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    cl_read    = 4'hF;
    cl_write   = 4'h0;
    cl_address = '0;
    cl_wdata   = '0;
    mem_resp   = 1'b1;
    mem_rdata  = 16'h5A5A;

    // Reset: outputs quiet even with requests and mem_resp active.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_strobe[%0d]", d), 32'(mrd[d] | mwr[d]), 32'd0);
      check($sformatf("rst_resp[%0d]", d), 32'(resp_all[d]), 32'd0);
      check($sformatf("rst_addr[%0d]", d), 32'(maddr[d]), 32'd0);
      check($sformatf("rst_wdata[%0d]", d), 32'(mwd[d]), 32'd0);
      check($sformatf("rst_rdata[%0d]", d), 32'(rd_all[d]), 32'h5A5A);
    end
    rst      = 1'b0;
    cl_read  = 4'h0;
    mem_resp = 1'b0;

    // Port 1 read, memory answers 3 cycles after the strobe; inputs scrambled while busy.
    drive(1, 1'b1, 1'b0, 16'h1234, 16'h1111);
    push_all(1, 1, 1, 1'b0, 16'h1234, 16'h1111);
    serve(3, 16'hBEEF, 1'b1);
    cl_read = 4'h0;

    // mem_resp while idle is ignored.
    @(negedge clk);
    mem_resp = 1'b1;
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("idle_resp_ignored[%0d]", d), 32'(resp_all[d]), 32'd0);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("idle_stays_idle[%0d]", d), 32'(mrd[d] | mwr[d]), 32'd0);

    // Ports 0 and 1 request continuously from reset: RR alternates, fixed priority starves port 1.
    do_reset(2);
    drive(0, 1'b1, 1'b0, 16'h0100, 16'h00A0);
    drive(1, 1'b1, 1'b0, 16'h0101, 16'h00A1);
    for (int g = 0; g < 4; g++) begin
      push(0, g % 2, 1'b0, 16'h0100 + 16'(g % 2), 16'h00A0 + 16'(g % 2));
      push(1, 0,     1'b0, 16'h0100, 16'h00A0);
      push(2, g % 2, 1'b0, 16'h0100 + 16'(g % 2), 16'h00A0 + 16'(g % 2));
    end
    for (int g = 0; g < 4; g++) serve(g, 16'hC000 + 16'(g), 1'b0);
    cl_read = 4'h0;

    // Move rr_ptr to 1, then abort a port 0 write with reset.
    drive(0, 1'b1, 1'b0, 16'h0060, 16'h0003);
    push_all(0, 0, 0, 1'b0, 16'h0060, 16'h0003);
    serve(0, 16'h0606, 1'b0);
    cl_read = 4'h0;
    drive(0, 1'b0, 1'b1, 16'h0040, 16'h0077);
    push_all(0, 0, 0, 1'b1, 16'h0040, 16'h0077);
    await_grant();
    @(negedge clk);
    rst      = 1'b1;
    cl_write = 4'h0;
    @(negedge clk);
    rst       = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("abort_resp[%0d]", d), 32'(resp_all[d]), 32'd0);
      check($sformatf("abort_strobe[%0d]", d), 32'(mrd[d] | mwr[d]), 32'd0);
    end
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("abort_idle[%0d]", d), 32'(mrd[d] | mwr[d]), 32'd0);
    // rr_ptr back at 0: port 0 beats port 1.
    drive(0, 1'b1, 1'b0, 16'h0050, 16'h0001);
    drive(1, 1'b1, 1'b0, 16'h0051, 16'h0002);
    push_all(0, 0, 0, 1'b0, 16'h0050, 16'h0001);
    serve(1, 16'h1234, 1'b0);
    cl_read = 4'h0;

    // Read and write together: only the write goes out.
    drive(0, 1'b1, 1'b1, 16'h0200, 16'h00AA);
    push_all(0, 0, 0, 1'b1, 16'h0200, 16'h00AA);
    serve(2, 16'h0000, 1'b0);
    cl_read  = 4'h0;
    cl_write = 4'h0;

    // 4-port wrap: grant port 2 (rr_ptr=3), then ports 0 and 2 -> 0 wins, then 2.
    do_reset(1);
    drive(2, 1'b1, 1'b0, 16'h0300, 16'h0033);
    push(2, 2, 1'b0, 16'h0300, 16'h0033);
    serve(1, 16'h3333, 1'b0);
    drive(0, 1'b1, 1'b0, 16'h0310, 16'h0044);
    push_all(0, 0, 0, 1'b0, 16'h0310, 16'h0044);
    serve(0, 16'h4444, 1'b0);
    push_all(0, 0, 2, 1'b0, 16'h0310, 16'h0044);
    q2[0].addr  = 16'h0300;
    q2[0].wdata = 16'h0033;
    serve(1, 16'h5555, 1'b0);
    cl_read = 4'h0;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("queue_drained[%0d]", d), 32'(qsize(d)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of client ports, legal range 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: data width.
REQ-004 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin arbitration, 1 = fixed priority with lowest index highest.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port cl_read  in  NUM_PORTS  per-client read request.
REQ-008 SHALL have port cl_write  in  NUM_PORTS  per-client write request.
REQ-009 SHALL have port cl_address  in  NUM_PORTS*ADDR_WIDTH  per-client address, packed with port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port cl_wdata  in  NUM_PORTS*DATA_WIDTH  per-client write data, packed the same way.
REQ-011 SHALL have port cl_resp  out  NUM_PORTS  per-client completion pulse.
REQ-012 SHALL have port cl_rdata  out  DATA_WIDTH  read data broadcast to all clients.
REQ-013 SHALL have port mem_read and mem_write  out  1 each  request strobes to the shared memory.
REQ-014 SHALL have port mem_address  out  ADDR_WIDTH and mem_wdata  out  DATA_WIDTH  request fields to the shared memory.
REQ-015 SHALL have port mem_resp  in  1 and mem_rdata  in  DATA_WIDTH  completion and read data from the shared memory.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and BUSY, with registers grant_idx, lat_addr, lat_wdata, lat_op and rr_ptr.
REQ-017 In IDLE, a client i is requesting when cl_read[i] or cl_write[i] is high; if any client is requesting, the block SHALL select a winner, latch its index, address, wdata and op at the rising edge, and enter BUSY.
REQ-018 In round-robin mode, the winner SHALL be the first requesting index found searching upward from rr_ptr, wrapping from NUM_PORTS-1 to 0.
REQ-019 In fixed-priority mode, the winner SHALL be the lowest requesting index, and rr_ptr SHALL be ignored.
REQ-020 If the winning client asserts both cl_read and cl_write, the write SHALL be performed, and no read SHALL be issued for that grant.
REQ-021 In BUSY, mem_read or mem_write SHALL be driven from lat_op, with mem_address = lat_addr and mem_wdata = lat_wdata; both strobes SHALL be 0 in IDLE.
REQ-022 The first memory strobe SHALL appear in the cycle after the request is sampled, giving a minimum arbitration latency of 1 cycle.
REQ-023 While BUSY, latched fields SHALL be stable regardless of client input changes.
REQ-024 cl_resp[grant_idx] SHALL equal mem_resp AND (state==BUSY), combinationally; every other cl_resp bit SHALL be 0.
REQ-025 cl_rdata SHALL equal mem_rdata combinationally at all times.
REQ-026 When mem_resp is high in BUSY, the FSM SHALL return to IDLE at the next edge.
REQ-027 On that same edge, rr_ptr SHALL become (grant_idx+1) mod NUM_PORTS.
REQ-028 mem_resp in IDLE SHALL be ignored: no cl_resp, no state change.
REQ-029 Clients SHALL hold their request until their cl_resp; a request dropped before its grant SHALL simply not be served.
REQ-030 Back-to-back transactions SHALL have one IDLE cycle between them, and a different client SHALL be able to win in that cycle.
REQ-031 Round-robin fairness: with all ports continuously requesting, each port SHALL be served once per NUM_PORTS grants.

Reset
REQ-032 While rst is high at a rising edge, the FSM SHALL go to IDLE, and rr_ptr, grant_idx, lat_addr, lat_wdata and lat_op SHALL reset to 0.
REQ-033 During reset, all outputs SHALL be 0 except cl_rdata, which follows mem_rdata.
REQ-034 Reset during BUSY SHALL abort the transaction: no cl_resp, and strobes drop in the cycle after the reset edge.
REQ-035 A memory response arriving after an abort SHALL be discarded per REQ-028.

Verification
REQ-036 Scenario: NUM_PORTS=2, port1 read 0x1234, memory responds 3 cycles after the strobe with 0xBEEF -> mem_read high 1 cycle after request; cl_resp=2'b10 for exactly one cycle; cl_rdata=0xBEEF.
REQ-037 Scenario: RR mode, ports 0 and 1 both request continuously from reset -> grant order 0,1,0,1, with one IDLE cycle between grants.
REQ-038 Scenario: FIXED_PRIO=1, ports 0 and 1 both request continuously -> port 0 served every grant and port 1 starved, as required.
REQ-039 Scenario: NUM_PORTS=4, rr_ptr=3, ports 0 and 2 requesting -> port 0 wins (wrap), and rr_ptr becomes 1 afterwards.
REQ-040 Scenario: rst asserted in BUSY during a port0 write to 0x0040, memory responds 2 cycles later -> no cl_resp, mem_write low after the reset edge, FSM IDLE, rr_ptr=0.
REQ-041 Scenario: port0 asserts read and write together, wdata 0x00AA -> only mem_write asserted, mem_wdata=0x00AA, cl_resp[0] pulses once.
